// File: rtl/frame_pixel_streamer_pkg.sv
// Shared constants and types for the frame pixel streamer and its block shifter.
package frame_pkg;

    localparam int PIX_W            = 24;
    localparam int BLOCK_W          = 6144;
    localparam int H_ACTIVE         = 1024;
    localparam int V_ACTIVE         = 768;
    localparam int PIX_PER_BLOCK    = BLOCK_W / PIX_W;
    localparam int BLOCKS_PER_FRAME = (H_ACTIVE * V_ACTIVE) / PIX_PER_BLOCK;
    localparam int PIX_IDX_W        = $clog2(PIX_PER_BLOCK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } state_t;

endpackage

// File: rtl/frame_pixel_streamer_if.sv
// Pixel stream bus towards the display/encoder stage.
// Handshake: a beat transfers on a rising clk edge where pix_valid & pix_ready;
// once pix_valid is high, pix_data/pix_sof/pix_eol hold until that transfer,
// and pix_valid never depends combinationally on pix_ready.
interface frame_pixel_streamer_if;
    import frame_pkg::*;

    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;
    logic             pix_ready;
    logic             pix_sof;
    logic             pix_eol;

    modport master (
        output pix_data,
        output pix_valid,
        output pix_sof,
        output pix_eol,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        input  pix_sof,
        input  pix_eol,
        output pix_ready
    );

endinterface

// File: rtl/frame_pixel_streamer_block_shifter.sv
// One-block shift register: loads a full reader block and presents its pixels
// MSB-first, one per shift, tracking the index of the pixel on the output.
module block_shifter
    import frame_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [BLOCK_W-1:0]   data_i,
    input  logic                 shift_i,
    output logic [PIX_W-1:0]     pix_o,
    output logic                 valid_o,
    output logic [PIX_IDX_W-1:0] pix_idx_o
);

    logic [BLOCK_W-1:0]   shift_q, shift_d;
    logic                 full_q, full_d;
    logic [PIX_IDX_W-1:0] idx_q, idx_d;

    // Load has priority: it coincides with the final shift for a gapless hand-off.
    always_comb begin
        shift_d = shift_q;
        full_d  = full_q;
        idx_d   = idx_q;
        if (load_i) begin
            shift_d = data_i;
            full_d  = 1'b1;
            idx_d   = '0;
        end else if (shift_i && full_q) begin
            shift_d = {shift_q[BLOCK_W-PIX_W-1:0], {PIX_W{1'b0}}};
            idx_d   = idx_q + 1'b1;
            if (idx_q == PIX_IDX_W'(PIX_PER_BLOCK - 1)) begin
                full_d = 1'b0;
            end
        end
    end

    // Shift register state.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            full_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            full_q  <= full_d;
            idx_q   <= idx_d;
        end
    end

    assign pix_o     = shift_q[BLOCK_W-1 -: PIX_W];
    assign valid_o   = full_q;
    assign pix_idx_o = idx_q;

endmodule

// File: rtl/frame_pixel_streamer.sv
// Requests blocks from the DDR frame reader, double-buffers them (shadow +
// shifter) and emits a raster as a valid/ready pixel stream with SOF/EOL.
module frame_pixel_streamer
    import frame_pkg::*;
#(
    parameter int H_ACT = H_ACTIVE,
    parameter int V_ACT = V_ACTIVE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ram_init,
    input  logic                 phy_init_done,
    input  logic                 start,
    output logic                 new_frame,
    output logic                 ask_data,
    input  logic [BLOCK_W-1:0]   read_data,
    input  logic                 block_valid,
    frame_pixel_streamer_if.master pix,
    output logic                 frame_done,
    output logic                 underrun,
    output state_t               dbg_state
);

    localparam int X_W = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int Y_W = (V_ACT > 1) ? $clog2(V_ACT) : 1;

    state_t               state_q, state_d;
    logic                 outstanding_q, outstanding_d;
    logic [BLOCK_W-1:0]   shadow_q, shadow_d;
    logic                 shadow_full_q, shadow_full_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic                 frame_done_q, frame_done_d;
    logic                 underrun_q, underrun_d;
    logic                 new_frame_q, new_frame_d;
    logic                 ask_data_q, ask_data_d;

    logic                 en;
    logic                 accept;
    logic                 bv_seen;
    logic                 capture;
    logic                 drop;
    logic                 load;
    logic                 ask_req;
    logic                 x_last;
    logic                 y_last;
    logic                 sh_valid;
    logic                 sh_last;
    logic [PIX_W-1:0]     sh_pix;
    logic [PIX_IDX_W-1:0] sh_idx;

    block_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load),
        .data_i    (shadow_q),
        .shift_i   (accept),
        .pix_o     (sh_pix),
        .valid_o   (sh_valid),
        .pix_idx_o (sh_idx)
    );

    // Handshake and buffer-movement qualifiers; init gating stops everything but the pixel beat.
    always_comb begin
        en      = ram_init & phy_init_done;
        accept  = sh_valid & pix.pix_ready;
        sh_last = (sh_idx == PIX_IDX_W'(PIX_PER_BLOCK - 1));
        bv_seen = en & block_valid & (state_q != IDLE);
        capture = bv_seen & ~shadow_full_q;
        drop    = bv_seen & shadow_full_q;
        load    = en & (state_q != IDLE) & shadow_full_q & (~sh_valid | (accept & sh_last));
        x_last  = (x_q == X_W'(H_ACT - 1));
        y_last  = (y_q == Y_W'(V_ACT - 1));
    end

    // Control FSM: new_frame is issued once, leaving IDLE; the reader keeps framing afterwards.
    always_comb begin
        state_d     = state_q;
        new_frame_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && start) begin
                    state_d     = PRIME;
                    new_frame_d = 1'b1;
                end
            end
            PRIME: begin
                if (capture) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                state_d = STREAM;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shadow buffer, request issue and sticky error tracking.
    always_comb begin
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        outstanding_d = outstanding_q;
        if (capture) begin
            shadow_d      = read_data;
            shadow_full_d = 1'b1;
        end else if (load) begin
            shadow_full_d = 1'b0;
        end
        // Ask only once the shadow will be empty after this cycle's load.
        ask_req    = en & (state_q == STREAM) & ~outstanding_q & ~shadow_full_d;
        ask_data_d = ask_req;
        if (new_frame_d) begin
            outstanding_d = 1'b1;
        end
        if (bv_seen) begin
            outstanding_d = 1'b0;
        end
        if (ask_req) begin
            outstanding_d = 1'b1;
        end
        underrun_d = underrun_q | drop |
                     (en & (state_q == STREAM) & ~sh_valid & ~shadow_full_q);
    end

    // Raster position follows accepted pixels only, so it survives stalls and starvation.
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        frame_done_d = 1'b0;
        if (accept) begin
            if (x_last) begin
                x_d = '0;
                if (y_last) begin
                    y_d          = '0;
                    frame_done_d = 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            outstanding_q <= 1'b0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_done_q  <= 1'b0;
            underrun_q    <= 1'b0;
            new_frame_q   <= 1'b0;
            ask_data_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_done_q  <= frame_done_d;
            underrun_q    <= underrun_d;
            new_frame_q   <= new_frame_d;
            ask_data_q    <= ask_data_d;
        end
    end

    assign pix.pix_data  = sh_pix;
    assign pix.pix_valid = sh_valid;
    assign pix.pix_sof   = sh_valid & (x_q == '0) & (y_q == '0);
    assign pix.pix_eol   = sh_valid & x_last;
    assign new_frame     = new_frame_q;
    assign ask_data      = ask_data_q;
    assign frame_done    = frame_done_q;
    assign underrun      = underrun_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Bench for frame_pixel_streamer with a reduced raster (512x3) so full frames fit.
module tb_frame_pixel_streamer;
  import frame_pkg::*;

  localparam int H = 512;
  localparam int V = 3;
  localparam int FRAME_PIX = H * V;

  logic clk = 1'b0;
  logic reset, ram_init, phy_init_done, start;
  logic new_frame, ask_data, block_valid, frame_done, underrun;
  logic [BLOCK_W-1:0] read_data;
  logic [BLOCK_W-1:0] blk;
  state_t dbg_state;

  frame_pixel_streamer_if pix_bus();

  frame_pixel_streamer #(.H_ACT(H), .V_ACT(V)) dut (
    .clk           (clk),
    .reset         (reset),
    .ram_init      (ram_init),
    .phy_init_done (phy_init_done),
    .start         (start),
    .new_frame     (new_frame),
    .ask_data      (ask_data),
    .read_data     (read_data),
    .block_valid   (block_valid),
    .pix           (pix_bus),
    .frame_done    (frame_done),
    .underrun      (underrun),
    .dbg_state     (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [PIX_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_acc = 0;
  int nf_cnt = 0;
  int ask_cnt = 0;
  int fd_cnt = 0;
  int blocks_sent = 0;
  int gap_cnt = 0;
  int gated_req = 0;
  int first_valid_cyc = -1;
  int first_bv_cyc = -1;
  int delay_cnt = 0;
  bit first_valid_seen = 0;
  bit ask_before_bv = 0;
  bit gap_check = 0;
  bit expect_fd = 0;
  bit pending = 0;
  bit long_next = 0;
  bit gate_prev = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_acc(input int target, input int budget, input string name);
    int i = 0;
    while (n_acc < target && i < budget) begin
      @(posedge clk);
      i++;
    end
    check(name, 64'(n_acc >= target), 64'd1);
  endtask

  // reader model: answers each request after a delay with a fresh block
  initial begin
    block_valid = 1'b0;
    read_data   = '0;
    forever begin
      @(posedge clk);
      #2;
      block_valid = 1'b0;
      if (reset) begin
        pending = 0;
      end else if (pending) begin
        if (delay_cnt > 0) begin
          delay_cnt--;
        end else if (ram_init && phy_init_done) begin
          for (int i = 0; i < PIX_PER_BLOCK; i++) begin
            logic [PIX_W-1:0] pv;
            pv = (blocks_sent < 4) ? PIX_W'(i) : PIX_W'($urandom);
            blk[BLOCK_W-1-i*PIX_W -: PIX_W] = pv;
            exp_q.push_back(pv);
          end
          read_data   = blk;
          block_valid = 1'b1;
          pending     = 0;
          blocks_sent++;
          if (first_bv_cyc < 0) first_bv_cyc = cyc;
        end
      end
    end
  end

  // monitor: request tracking, pixel scoreboard, frame_done and stall checks
  initial begin
    logic [PIX_W-1:0] e;
    logic [PIX_W-1:0] prev_data;
    bit prev_stall, prev_sof, prev_eol, gate_now;
    int x, y;
    prev_stall = 0;
    prev_data = '0;
    prev_sof = 0;
    prev_eol = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 0;
      end else begin
        gate_now = ram_init && phy_init_done;
        if ((new_frame || ask_data) && !gate_now && !gate_prev) gated_req++;
        gate_prev = gate_now;
        if (new_frame) nf_cnt++;
        if (ask_data) begin
          ask_cnt++;
          if (first_bv_cyc < 0) ask_before_bv = 1;
        end
        if (new_frame || ask_data) begin
          check("single_outstanding", 64'(pending), 64'd0);
          pending = 1;
          delay_cnt = long_next ? 300 : $urandom_range(200, 5);
          long_next = 0;
        end
        check("frame_done", 64'(frame_done), 64'(expect_fd));
        if (frame_done) fd_cnt++;
        expect_fd = 0;
        if (prev_stall) begin
          check("stall_valid", 64'(pix_bus.pix_valid), 64'd1);
          check("stall_data", 64'(pix_bus.pix_data), 64'(prev_data));
          check("stall_sof", 64'(pix_bus.pix_sof), 64'(prev_sof));
          check("stall_eol", 64'(pix_bus.pix_eol), 64'(prev_eol));
        end
        if (pix_bus.pix_valid && !first_valid_seen) begin
          first_valid_seen = 1;
          first_valid_cyc = cyc;
        end
        if (gap_check && first_valid_seen && !pix_bus.pix_valid) gap_cnt++;
        if (pix_bus.pix_valid && pix_bus.pix_ready) begin
          x = n_acc % H;
          y = (n_acc / H) % V;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL pix_unexpected: got %0h expected none", pix_bus.pix_data);
          end else begin
            e = exp_q.pop_front();
            check("pix_data", 64'(pix_bus.pix_data), 64'(e));
          end
          check("pix_sof", 64'(pix_bus.pix_sof), 64'(x == 0 && y == 0));
          check("pix_eol", 64'(pix_bus.pix_eol), 64'(x == H - 1));
          if ((n_acc % FRAME_PIX) == FRAME_PIX - 1) expect_fd = 1;
          n_acc++;
        end
        prev_stall = pix_bus.pix_valid && !pix_bus.pix_ready;
        prev_data = pix_bus.pix_data;
        prev_sof = pix_bus.pix_sof;
        prev_eol = pix_bus.pix_eol;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_new_frame"}, 64'(new_frame), 64'd0);
    check({tag, "_ask_data"}, 64'(ask_data), 64'd0);
    check({tag, "_pix_valid"}, 64'(pix_bus.pix_valid), 64'd0);
    check({tag, "_pix_sof"}, 64'(pix_bus.pix_sof), 64'd0);
    check({tag, "_pix_eol"}, 64'(pix_bus.pix_eol), 64'd0);
    check({tag, "_pix_data"}, 64'(pix_bus.pix_data), 64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check({tag, "_underrun"}, 64'(underrun), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_first_valid(input string tag);
    for (int i = 0; i < 1000 && !first_valid_seen; i++) @(posedge clk);
    check({tag, "_first_valid_seen"}, 64'(first_valid_seen), 64'd1);
    check({tag, "_valid_latency"}, 64'(first_valid_cyc - first_bv_cyc), 64'd2);
    check({tag, "_no_ask_before_block"}, 64'(ask_before_bv), 64'd0);
    check({tag, "_new_frame_once"}, 64'(nf_cnt), 64'd1);
  endtask

  // driver / sequence
  initial begin
    reset = 1'b1;
    ram_init = 1'b0;
    phy_init_done = 1'b0;
    start = 1'b0;
    pix_bus.pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");

    // bring-up and two full frames with the sink always ready
    @(posedge clk); #1;
    reset = 1'b0;
    ram_init = 1'b1;
    phy_init_done = 1'b1;
    pix_bus.pix_ready = 1'b1;
    gap_check = 1;
    pulse_start();
    wait_first_valid("boot");
    check("state_stream", 64'(dbg_state), 64'(STREAM));
    wait_acc(2 * FRAME_PIX + 4, 20000, "two_frames_timeout");
    gap_check = 0;
    check("frame_done_count", 64'(fd_cnt), 64'd2);
    check("no_gaps", 64'(gap_cnt), 64'd0);
    check("no_underrun_ready", 64'(underrun), 64'd0);
    check("new_frame_not_reissued", 64'(nf_cnt), 64'd1);

    // random backpressure, plus a start pulse that must be ignored
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      pix_bus.pix_ready = 1'($urandom_range(1, 0));
      start = (i == 100);
    end
    start = 1'b0;
    check("start_ignored", 64'(nf_cnt), 64'd1);
    check("ask_per_block", 64'(ask_cnt + nf_cnt), 64'(blocks_sent + int'(pending)));
    check("no_underrun_random", 64'(underrun), 64'd0);

    // starve the stream with one slow block
    pix_bus.pix_ready = 1'b1;
    long_next = 1;
    for (int i = 0; i < 2000 && !underrun; i++) @(posedge clk);
    check("underrun_set", 64'(underrun), 64'd1);
    wait_acc(n_acc + 600, 5000, "resume_timeout");
    check("underrun_sticky", 64'(underrun), 64'd1);

    // drop PHY calibration: no requests, shifter drains and stays empty
    @(posedge clk); #1;
    phy_init_done = 1'b0;
    repeat (400) @(posedge clk);
    @(negedge clk);
    check("gated_requests", 64'(gated_req), 64'd0);
    check("gated_drained", 64'(pix_bus.pix_valid), 64'd0);
    @(posedge clk); #1;
    phy_init_done = 1'b1;
    wait_acc(n_acc + 600, 5000, "ungate_timeout");

    // reset mid-frame, then restart
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("midreset");
    exp_q.delete();
    n_acc = 0;
    nf_cnt = 0;
    ask_cnt = 0;
    fd_cnt = 0;
    blocks_sent = 0;
    expect_fd = 0;
    first_valid_seen = 0;
    first_valid_cyc = -1;
    first_bv_cyc = -1;
    ask_before_bv = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    pulse_start();
    wait_first_valid("restart");
    wait_acc(700, 5000, "restart_timeout");
    check("restart_no_underrun", 64'(underrun), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_pixel_streamer.md
Name: frame_pixel_streamer

Overview:
- Downstream consumer of the DDR frame reader.
- Takes the 6144-bit block the reader assembles (8 bursts x 768 bits = 256 pixels of 24 bpp) and drives the reader's new_frame/ask_data request pins.
- Double-buffers blocks and emits a 1024x768 raster as a valid/ready pixel stream with start-of-frame and end-of-line markers for the display/encoder stage.

Parameters:
PIX_W, 24, bits per pixel
BLOCK_W, 6144, bits per reader block
H_ACTIVE, 1024, pixels per line (multiple of BLOCK_W/PIX_W)
V_ACTIVE, 768, lines per frame

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ram_init  in  1  RAM controller initialised
phy_init_done  in  1  DDR PHY calibrated
start  in  1  one-cycle pulse: begin streaming
new_frame  out  1  to reader: first-fetch request
ask_data  out  1  to reader: next-block request
read_data  in  6144  block from reader; pixel 0 in bits [6143:6120]
block_valid  in  1  one-cycle pulse: read_data complete and stable this cycle
pix_data  out  24  pixel
pix_valid  out  1  pix_data valid
pix_ready  in  1  downstream accepts when valid&ready
pix_sof  out  1  qualifies first pixel of frame
pix_eol  out  1  qualifies last pixel of line
frame_done  out  1  one-cycle pulse after last pixel of frame accepted
underrun  out  1  sticky: stream starved mid-frame

Behaviour:
- Reset: every output 0; state IDLE; shift/shadow flags empty; outstanding=0; counters 0.
- Gate: if !(ram_init & phy_init_done), hold all state and do not assert new_frame/ask_data. The pixel handshake still completes an already-valid beat.
- States:
  - IDLE: on start -> new_frame=1 for exactly 1 cycle, outstanding=1, go PRIME.
  - PRIME: wait for block_valid.
  - STREAM: steady state.
  - start outside IDLE is ignored. new_frame is issued once per reset only, because the reader latches framing.
- Shadow capture: on block_valid, shadow <= read_data, shadow_full=1, outstanding=0. Capture completes in the block_valid cycle, so the reader may overwrite its registers from the next cycle. block_valid while shadow_full=1 is a protocol error: the block is dropped and underrun is set.
- Load: when shift is empty (or its last pixel is accepted this cycle) and shadow_full=1: shift <= shadow, pix_idx=0, shadow_full=0. Zero-bubble hand-off, same cycle.
- Request: ask_data=1 for one cycle when state=STREAM, outstanding=0 and shadow_full=0 (after any load that cycle). Sets outstanding=1. Never more than one request outstanding.
- PRIME->STREAM: on the first block_valid. The block is moved to shift the next cycle. pix_valid first rises 2 cycles after block_valid.
- Output:
  - pix_valid = shift holds data.
  - pix_data = shift[BLOCK_W-1 -: PIX_W].
  - On accept, shift <<= PIX_W and pix_idx++ (8-bit, 0..255). Pixel 255 accepted -> shift empty.
- Raster counters:
  - x 0..H_ACTIVE-1 and y 0..V_ACTIVE-1, advancing on accept.
  - pix_sof = (x==0 && y==0) & pix_valid.
  - pix_eol = (x==H_ACTIVE-1) & pix_valid.
  - Wrap x at H_ACTIVE; y at V_ACTIVE -> 0, with frame_done pulsing the following cycle.
  - Streaming continues seamlessly into the next frame; the reader wraps its address at the same time.
- Starvation: pix_valid=0 with shift and shadow both empty in STREAM sets underrun (sticky until reset). Counters hold; the stream resumes on the next block.
- Backpressure: pix_data/pix_sof/pix_eol are stable while pix_valid & !pix_ready.
- Reset mid-frame: immediate return to reset values. Any outstanding block_valid after reset is ignored in IDLE. The reader shares the reset, so framing restarts cleanly.

Decomposition:
- Package frame_pkg holds:
  - PIX_W, BLOCK_W, H_ACTIVE, V_ACTIVE
  - PIX_PER_BLOCK = BLOCK_W/PIX_W
  - BLOCKS_PER_FRAME = 3072
  - the state enum {IDLE, PRIME, STREAM}
- Sub-module block_shifter: 6144-bit shift register with load/shift/empty and pix_idx. It is natural to isolate and reused by the encoder path.

Test Plan:
- Reset then start with init high -> new_frame high exactly 1 cycle; no ask_data before first block_valid; pix_valid rises 2 cycles after block_valid; first pix_data = read_data[6143:6120] with pix_sof=1.
- Block with pixels 0x000000..0x0000FF, pix_ready always 1 -> 256 pixels in order, no gaps across 4 back-to-back blocks when block_valid arrives <256 cycles after ask_data; pix_eol on pixel 1023.
- Full frame, 3072 blocks -> 786432 accepts; frame_done pulses once; the next pixel has pix_sof=1 with no new_frame reissued.
- pix_ready toggling randomly 50% -> pix_data stable while stalled; exactly one ask_data per consumed block; never two outstanding.
- Delay block_valid 300 cycles after ask_data -> pix_valid drops, underrun=1 stays set, x/y preserved, stream resumes correctly.
- Drop phy_init_done mid-stream -> no new requests; reset asserted mid-frame -> all outputs 0 next cycle, start restarts with new_frame.
